// File: rtl/program_loader.sv
// Byte-stream boot loader: parses A5 | N(16b LE) | 4N data bytes | XOR checksum, writes words to instruction memory.
// Write strobe follows the 4th byte of each word by one cycle; in_ready is high in every state after reset.
module program_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog_load_en,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR} state_t;

  localparam logic [31:0] LP_MAX = 32'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_word;
  logic [7:0]  r_xor;
  logic        r_load_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_done;
  logic        r_error;
  logic        r_hold;

  logic        w_accept;
  logic        w_sync;
  logic [15:0] w_n;
  logic        w_n_bad;
  logic        w_last_byte;
  logic        w_last_word;

  assign w_accept    = in_valid & r_ready;
  assign w_sync      = w_accept && (in_data == 8'hA5);
  assign w_n         = {in_data, r_count[7:0]};
  assign w_n_bad     = (w_n == 16'd0) || ({16'd0, w_n} > LP_MAX);
  assign w_last_byte = (r_bcnt == 2'd3);
  assign w_last_word = ((r_idx + 16'd1) == r_count);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (w_sync) w_next = CNT_LO;
      CNT_LO:            if (w_accept) w_next = CNT_HI;
      CNT_HI:            if (w_accept) w_next = w_n_bad ? ERROR : DATA;
      DATA:              if (w_accept && w_last_byte && w_last_word) w_next = CHECK;
      CHECK:             if (w_accept) w_next = (in_data == r_xor) ? DONE : ERROR;
      default:           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Status flags are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      r_done  <= (w_next == DONE);
      r_error <= (w_next == ERROR);
      r_hold  <= (w_next != DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_count   <= 16'd0;
      r_idx     <= 16'd0;
      r_bcnt    <= 2'd0;
      r_word    <= 24'd0;
      r_xor     <= 8'd0;
      r_load_en <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_data    <= 32'd0;
    end else begin
      r_ready   <= 1'b1;
      r_load_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_sync) begin
            r_count <= 16'd0;
            r_idx   <= 16'd0;
            r_bcnt  <= 2'd0;
            r_xor   <= 8'd0;
          end
        end
        CNT_LO: if (w_accept) r_count[7:0] <= in_data;
        CNT_HI: begin
          if (w_accept) begin
            r_count[15:8] <= in_data;
            r_idx         <= 16'd0;
            r_bcnt        <= 2'd0;
          end
        end
        DATA: begin
          if (w_accept) begin
            // Little-endian: bytes shift in from the top, so the 4th byte lands in bits 31:24.
            r_xor  <= r_xor ^ in_data;
            r_bcnt <= r_bcnt + 2'd1;
            r_word <= {in_data, r_word[23:8]};
            if (w_last_byte) begin
              r_load_en <= 1'b1;
              r_addr    <= BASE_ADDR + {14'd0, r_idx, 2'b00};
              r_data    <= {in_data, r_word};
              r_idx     <= r_idx + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign prog_load_en = r_load_en;
  assign prog_addr    = r_addr;
  assign prog_data    = r_data;
  assign cpu_hold     = r_hold;
  assign load_done    = r_done;
  assign load_error   = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are built from word lists, expected writes queued, strobes checked by a monitor.
module tb_program_loader;

  localparam int          MAX_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        prog_load_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  program_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prog_load_en(prog_load_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  logic [31:0] exp_last_addr;
  logic [31:0] exp_last_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every strobe cycle must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t e;
    if (prog_load_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got addr 0x%08h data 0x%08h, expected no strobe", prog_addr, prog_data);
      end else begin
        e = exp_q.pop_front();
        check32("strobe_addr", prog_addr, e.addr);
        check32("strobe_data", prog_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready %b, expected 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
    @(negedge clk);
    check32({tag, "_done"},  {31'd0, load_done},  {31'd0, exp_done});
    check32({tag, "_error"}, {31'd0, load_error}, {31'd0, exp_err});
    check32({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, ~exp_done});
    check32({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    check32({tag, "_held_addr"}, prog_addr, exp_last_addr);
    check32({tag, "_held_data"}, prog_data, exp_last_data);
  endtask

  // Reference: a frame of N words writes word k at BASE+4k; it succeeds iff the checksum equals the XOR of all data bytes.
  task automatic send_frame(input string tag, input logic [7:0] ck_err, input int gap_mode);
    logic [15:0] n16;
    logic [7:0]  ck;
    logic [31:0] w;
    wr_t         e;
    n16 = 16'(frame_words.size());
    ck  = 8'h00;
    for (int k = 0; k < frame_words.size(); k++) begin
      w  = frame_words[k];
      ck = ck ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      e.addr = BASE_ADDR + 32'(4 * k);
      e.data = w;
      exp_q.push_back(e);
      exp_last_addr = e.addr;
      exp_last_data = e.data;
    end
    ck = ck ^ ck_err;
    send_byte(8'hA5, pick_gap(gap_mode));
    send_byte(n16[7:0], pick_gap(gap_mode));
    send_byte(n16[15:8], pick_gap(gap_mode));
    for (int k = 0; k < frame_words.size(); k++) begin
      w = frame_words[k];
      send_byte(w[7:0],   pick_gap(gap_mode));
      send_byte(w[15:8],  pick_gap(gap_mode));
      send_byte(w[23:16], pick_gap(gap_mode));
      send_byte(w[31:24], pick_gap(gap_mode));
    end
    send_byte(ck, pick_gap(gap_mode));
    check_status(tag, ck_err == 8'h00, ck_err != 8'h00);
  endtask

  task automatic send_bad_count(input string tag, input logic [15:0] n);
    send_byte(8'hA5, 0);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    check_status(tag, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_q.delete();
    exp_last_addr = BASE_ADDR;
    exp_last_data = 32'd0;
    @(negedge clk);
    check32("rst_hold",     {31'd0, cpu_hold},     32'd1);
    check32("rst_in_ready", {31'd0, in_ready},     32'd0);
    check32("rst_load_en",  {31'd0, prog_load_en}, 32'd0);
    check32("rst_addr",     prog_addr,             BASE_ADDR);
    check32("rst_data",     prog_data,             32'd0);
    check32("rst_done",     {31'd0, load_done},    32'd0);
    check32("rst_error",    {31'd0, load_error},   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check32("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset();

    frame_words = '{32'h00A00513};
    send_frame("single", 8'h00, 0);

    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    check_status("done_hold", 1'b1, 1'b0);

    frame_words = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_frame("three", 8'h00, 0);

    send_bad_count("count_zero", 16'h0000);
    send_byte(8'hFF, 0);
    check_status("error_hold", 1'b0, 1'b1);

    send_bad_count("count_over", 16'(MAX_WORDS + 1));

    frame_words = '{32'h00A00513};
    send_frame("bad_ck", 8'h01, 0);
    send_frame("after_bad_ck", 8'h00, 0);

    // Abandoned frame: reset after the 3rd data byte must not produce a write.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'hA0, 0);
    do_reset();
    send_frame("reload", 8'h00, 0);

    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_frame("garbage_toggle", 8'h00, 1);

    frame_words.delete();
    for (int k = 0; k < MAX_WORDS; k++) frame_words.push_back($urandom);
    send_frame("max_words", 8'h00, 0);

    for (int f = 0; f < 8; f++) begin
      frame_words.delete();
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) frame_words.push_back($urandom);
      if ($urandom_range(0, 3) == 0) send_frame("rand_bad", 8'(1 << $urandom_range(0, 7)), 2);
      else                           send_frame("rand_ok", 8'h00, 2);
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, SHALL set the largest accepted program size in 32-bit words; 1024 matches 4 KB instruction memory.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first program word.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_data, input, 8 bits, SHALL carry the incoming load-stream byte.
REQ-006 Port in_valid, input, 1 bit, SHALL flag in_data as valid.
REQ-007 Port in_ready, output, 1 bit, SHALL flag that the loader accepts a byte this cycle.
REQ-008 Port prog_load_en, output, 1 bit, SHALL be the instruction-memory write strobe.
REQ-009 Port prog_addr, output, 32 bits, SHALL be the instruction-memory byte write address.
REQ-010 Port prog_data, output, 32 bits, SHALL be the instruction-memory write word.
REQ-011 Port cpu_hold, output, 1 bit, SHALL hold the processor in reset while high.
REQ-012 Port load_done, output, 1 bit, SHALL flag a completed, checksum-verified load.
REQ-013 Port load_error, output, 1 bit, SHALL flag an aborted load.

Function
REQ-014 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 in every state after reset.
REQ-015 The frame SHALL be, in order:
- sync byte 8'hA5;
- word count N, 16 bits, low byte first;
- 4N data bytes, each word little-endian (first byte = bits 7:0);
- one checksum byte = XOR of all 4N data bytes.
REQ-016 The FSM SHALL have states IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR.
REQ-017 Transitions from IDLE and CNT_LO:
- IDLE: accepted 8'hA5 -> CNT_LO; any other byte is discarded and the state stays IDLE.
- CNT_LO: accepted byte -> CNT_HI.
REQ-018 CNT_HI: an accepted byte completes N.
- N = 0 or N > MAX_WORDS -> ERROR.
- Otherwise -> DATA, with word index and byte counter cleared.
REQ-019 Word assembly in DATA:
- On the 4th accepted byte of word k, the next cycle SHALL drive prog_load_en = 1 for exactly one cycle.
- prog_addr = BASE_ADDR + 4*k (32-bit wrap) and prog_data = the assembled word during that cycle.
- Latency from 4th byte accept to strobe SHALL be 1 cycle.
REQ-020 After word N-1 is accepted, the FSM SHALL go to CHECK; byte acceptance SHALL continue during a strobe cycle.
REQ-021 CHECK: the accepted byte is compared with the running XOR.
- Equal -> DONE.
- Unequal -> ERROR.
REQ-022 DONE and ERROR exit:
- Accepted 8'hA5 -> CNT_LO, clearing load_done and load_error and reasserting cpu_hold in the next cycle.
- Any other byte is discarded and the state is held.
REQ-023 cpu_hold SHALL be 0 only in DONE.
REQ-024 load_done SHALL be 1 only in DONE, and load_error only in ERROR; both SHALL be registered.
REQ-025 The running XOR SHALL be cleared on entry to CNT_LO.
REQ-026 Words already written before an error SHALL remain in memory; the loader SHALL NOT erase them.
REQ-027 prog_load_en SHALL be 0 in every cycle other than REQ-019 strobes.
REQ-028 prog_addr and prog_data SHALL hold their last values when the strobe is low.

Reset
REQ-029 While reset is high, the loader SHALL be in IDLE with all of the following:
- cpu_hold = 1, in_ready = 0;
- prog_load_en = 0, prog_addr = BASE_ADDR, prog_data = 0;
- load_done = 0, load_error = 0;
- counters and XOR = 0.
REQ-030 in_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-frame, including during a strobe cycle, SHALL drop prog_load_en immediately and abandon the frame; no partial word is ever written.

Verification
REQ-032 Single word: bytes A5,01,00,13,05,A0,00,B6 -> one strobe with prog_addr 0x0, prog_data 0x00A00513; then load_done = 1, cpu_hold = 0.
REQ-033 Three words 0x11111111, 0x22222222, 0x33333333, checksum 0x00 -> strobes at addresses 0x0, 0x4, 0x8, then DONE.
REQ-034 Bad frames:
- Count bytes 00,00 -> ERROR, no strobes.
- Count 0x0401 with MAX_WORDS = 1024 -> ERROR.
REQ-035 Single-word frame with checksum 0xB7 instead of 0xB6 -> one strobe, then load_error = 1, cpu_hold stays 1; a following valid frame -> DONE.
REQ-036 Reset pulsed after the 3rd data byte -> no strobe; the following valid frame reloads from address 0x0.
REQ-037 Garbage bytes 00,FF in IDLE, then a valid frame with in_valid toggling every cycle -> garbage ignored, results identical to REQ-032.
